// File: rtl/tt_sweep_checker_if.sv
// Bundle between the sweep checker and the function block it exercises,
// including the start/busy/done handshake and the captured results.
interface tt_sweep_checker_if;
  logic         start;
  logic [6:0]   x;
  logic         out;
  logic         busy;
  logic         done;
  logic [127:0] tt;
  logic [7:0]   ones_count;
  logic [7:0]   mismatch_count;
  logic [6:0]   first_mismatch;
  logic         pass;

  // Checker side: drives the vectors and results, receives start and out.
  modport master (
    input  start,
    input  out,
    output x,
    output busy,
    output done,
    output tt,
    output ones_count,
    output mismatch_count,
    output first_mismatch,
    output pass
  );

  // Environment side: issues start, supplies the response, reads results.
  modport slave (
    output start,
    output out,
    input  x,
    input  busy,
    input  done,
    input  tt,
    input  ones_count,
    input  mismatch_count,
    input  first_mismatch,
    input  pass
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: walks x through all 128 vectors, captures the
// response of the block under test through a latency-matched tag pipeline,
// and compares the assembled table against a golden table.
module tt_sweep_checker #(
  parameter int           DUT_LAT     = 0,
  parameter logic [127:0] EXPECTED_TT = 128'hfeeaeaa8eaa8e880fee8eaa8eaa8a880
) (
  input  logic               clk,
  input  logic               rst,
  tt_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic         accept;
  logic         issue;
  logic         finish;
  logic         clear_x;

  logic [6:0]   idx;
  logic [6:0]   x_q;

  logic [DUT_LAT:0] pipe_valid;
  logic [6:0]       pipe_idx [DUT_LAT:0];
  logic             emerge_valid;
  logic [6:0]       emerge_idx;
  logic             pipe_empty;

  logic [127:0] tt_q;
  logic [7:0]   ones_q;
  logic [7:0]   mism_q;
  logic [6:0]   first_q;
  logic         pass_q;

  assign emerge_valid = pipe_valid[DUT_LAT];
  assign emerge_idx   = pipe_idx[DUT_LAT];
  assign pipe_empty   = ~|pipe_valid;

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state control strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    clear_x    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        issue = 1'b1;
        if (idx == 7'd127) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        clear_x    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector generator: x lags the index counter by one edge so that each
  // index is tagged into the pipeline on the same edge it appears on x.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      x_q <= '0;
    end else if (accept) begin
      idx <= '0;
      x_q <= '0;
    end else if (issue) begin
      idx <= idx + 7'd1;
      x_q <= idx;
    end else if (clear_x) begin
      x_q <= '0;
    end
  end

  // Tag pipeline of depth DUT_LAT+1 so each index emerges together with
  // the response it produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i <= DUT_LAT; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_idx[0]   <= idx;
      for (int i = 1; i <= DUT_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
    end
  end

  // Result accumulation; the first mismatch is latched while the mismatch
  // count is still zero, which works because indices emerge in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q    <= '0;
      ones_q  <= '0;
      mism_q  <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else if (accept) begin
      tt_q    <= '0;
      ones_q  <= '0;
      mism_q  <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (emerge_valid) begin
        tt_q[emerge_idx] <= bus.out;
        ones_q           <= ones_q + {7'd0, bus.out};
        if (bus.out != EXPECTED_TT[emerge_idx]) begin
          mism_q <= mism_q + 8'd1;
          if (mism_q == 8'd0) begin
            first_q <= emerge_idx;
          end
        end
      end
      if (finish) begin
        pass_q <= (mism_q == 8'd0);
      end
    end
  end

  assign bus.x              = x_q;
  assign bus.busy           = (state == DRIVE) || (state == DRAIN);
  assign bus.done           = (state == DONE);
  assign bus.tt             = tt_q;
  assign bus.ones_count     = ones_q;
  assign bus.mismatch_count = mism_q;
  assign bus.first_mismatch = first_q;
  assign bus.pass           = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for the sweep checker: a zero-latency instance driven by several
// function models and a three-cycle-latency instance driven by a registered
// golden function. Expected results are queued when a sweep starts and
// compared when done appears.
module tb_tt_sweep_checker;

  localparam logic [127:0] GOLD = 128'hfeeaeaa8eaa8e880fee8eaa8eaa8a880;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] gold_tbl = GOLD;
  logic [127:0] tbl0 = '0;
  logic [2:0]   lat_pipe = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    logic [7:0]   mism;
    logic [6:0]   first;
    logic         pass;
    int           lat;
  } exp_t;

  exp_t sb[$];

  tt_sweep_checker_if bus0();
  tt_sweep_checker_if bus3();

  always #5 clk = ~clk;

  assign bus0.start = go & ~sel;
  assign bus3.start = go & sel;
  assign bus0.out   = tbl0[bus0.x];
  assign bus3.out   = lat_pipe[2];

  // Three-stage registered copy of the golden function for the latency instance.
  always @(posedge clk) begin
    lat_pipe <= {lat_pipe[1:0], gold_tbl[bus3.x]};
  end

  logic [6:0]   o_x;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_tt;
  logic [7:0]   o_ones;
  logic [7:0]   o_mism;
  logic [6:0]   o_first;
  logic         o_pass;

  assign o_x     = sel ? bus3.x              : bus0.x;
  assign o_busy  = sel ? bus3.busy           : bus0.busy;
  assign o_done  = sel ? bus3.done           : bus0.done;
  assign o_tt    = sel ? bus3.tt             : bus0.tt;
  assign o_ones  = sel ? bus3.ones_count     : bus0.ones_count;
  assign o_mism  = sel ? bus3.mismatch_count : bus0.mismatch_count;
  assign o_first = sel ? bus3.first_mismatch : bus0.first_mismatch;
  assign o_pass  = sel ? bus3.pass           : bus0.pass;

  tt_sweep_checker #(.DUT_LAT(0), .EXPECTED_TT(GOLD)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  tt_sweep_checker #(.DUT_LAT(3), .EXPECTED_TT(GOLD)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.master)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 golden, 1 tied low, 2 tied high, 3 golden with bit 42 inverted.
  function automatic logic [127:0] model_table(input int m);
    logic [127:0] t;
    t = gold_tbl;
    case (m)
      1: t = '0;
      2: t = '1;
      3: t[42] = ~t[42];
      default: t = gold_tbl;
    endcase
    return t;
  endfunction

  task automatic checkZero(input string tag);
    checkOutput({tag, "_x"}, o_x, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_tt"}, o_tt, 0);
    checkOutput({tag, "_ones"}, o_ones, 0);
    checkOutput({tag, "_mism"}, o_mism, 0);
    checkOutput({tag, "_first"}, o_first, 0);
    checkOutput({tag, "_pass"}, o_pass, 0);
  endtask

  task automatic applyStimulus(input int m, input logic s, input int abort_x, input bit repulse);
    exp_t e;
    exp_t got;
    logic [127:0] tbl;
    int n;
    int xerr;
    int berr;
    int extra;
    int exp_x;
    bit seen_done;
    bit pulsed;

    sel  = s;
    tbl  = s ? gold_tbl : model_table(m);
    tbl0 = tbl;
    e.tt    = tbl;
    e.ones  = 8'($countones(tbl));
    e.mism  = 8'($countones(tbl ^ gold_tbl));
    e.first = '0;
    for (int i = 127; i >= 0; i--) begin
      if (tbl[i] != gold_tbl[i]) e.first = 7'(i);
    end
    e.pass = (e.mism == 8'd0);
    e.lat  = s ? 3 : 0;
    if (abort_x < 0) sb.push_back(e);

    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0; xerr = 0; berr = 0; seen_done = 0; pulsed = 0;

    while (!seen_done && n < 400) begin
      if (o_done) begin
        seen_done = 1;
      end else begin
        exp_x = (n == 0) ? 0 : ((n <= 128) ? n - 1 : 127);
        if (o_x !== 7'(exp_x)) xerr++;
        if (o_busy !== 1'b1) berr++;
        if (abort_x >= 0 && o_x == 7'(abort_x)) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          checkZero("abort");
          extra = 0;
          for (int i = 0; i < 200; i++) begin
            tick();
            if (o_done || o_busy) extra++;
          end
          checkOutput("abort_no_done", extra, 0);
          checkOutput("abort_xseq_errs", xerr, 0);
          return;
        end
        if (repulse && o_x == 7'd20 && !pulsed) begin
          go = 1'b1;
          pulsed = 1;
        end else begin
          go = 1'b0;
        end
        tick();
        n++;
      end
    end
    go = 1'b0;

    if (!seen_done) begin
      checkOutput("timeout", 1, 0);
      return;
    end

    got = sb.pop_front();
    checkOutput("latency", n, got.lat + 130);
    checkOutput("xseq_errs", xerr, 0);
    checkOutput("busy_errs", berr, 0);
    checkOutput("busy_at_done", o_busy, 0);
    checkOutput("tt", o_tt, got.tt);
    checkOutput("ones_count", o_ones, got.ones);
    checkOutput("mismatch_count", o_mism, got.mism);
    checkOutput("first_mismatch", o_first, got.first);
    checkOutput("pass", o_pass, got.pass);

    if (repulse) go = 1'b1;
    tick();
    go = 1'b0;
    checkOutput("done_one_cycle", o_done, 0);
    checkOutput("x_back_to_zero", o_x, 0);
    checkOutput("tt_hold", o_tt, got.tt);
    checkOutput("pass_hold", o_pass, got.pass);
    if (repulse) begin
      extra = 0;
      for (int i = 0; i < 150; i++) begin
        tick();
        if (o_done || o_busy) extra++;
      end
      checkOutput("start_in_done_ignored", extra, 0);
    end
  endtask

  // Main sequence: reset state, function models, latency instance, abort, re-pulse.
  initial begin
    rst = 1'b1;
    repeat (2) tick();
    sel = 1'b0;
    checkZero("reset");
    checkOutput("reset_busy3", bus3.busy, 0);
    checkOutput("reset_tt3", bus3.tt, 0);
    rst = 1'b0;
    tick();

    applyStimulus(0, 1'b0, -1, 1'b0);
    checkOutput("golden_ones_const", o_ones, 64);
    applyStimulus(1, 1'b0, -1, 1'b0);
    checkOutput("tied0_first_const", o_first, 7);
    applyStimulus(2, 1'b0, -1, 1'b0);
    applyStimulus(3, 1'b0, -1, 1'b0);
    checkOutput("bit42_first_const", o_first, 42);
    applyStimulus(0, 1'b1, -1, 1'b0);
    applyStimulus(0, 1'b0, 50, 1'b0);
    applyStimulus(0, 1'b0, -1, 1'b0);
    applyStimulus(2, 1'b0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
